// File: rtl/eth_frame_builder.sv
// rtl/eth_frame_builder.sv - frames header + FIFO payload into one word stream for Ethernet TX
// Optional trailer checksum word is enabled by defining TRAILER_CHECKSUM_EN.
module eth_frame_builder #(
  parameter int          DW            = 16,
  parameter int          PAYLOAD_WORDS = 4096,
  parameter logic [15:0] SYNC_WORD     = 16'hA55A
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          h_en,
  input  logic [1:0]    Header_Address,
  input  logic          fifo_rd,
  input  logic          fifo_empty,
  input  logic [DW-1:0] fifo_dout,
  output logic [DW-1:0] tx_data,
  output logic          tx_valid,
  output logic          tx_sop,
  output logic          tx_eop,
  output logic          tx_err,
  output logic [2:0]    frame_status,
  output logic [15:0]   frames_sent
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_PAY  = 2'd2;
  localparam logic [1:0] K_HDR  = 2'd0;
  localparam logic [1:0] K_PAY  = 2'd1;
`ifdef TRAILER_CHECKSUM_EN
  localparam logic [1:0] S_TAIL = 2'd3;
  localparam logic [1:0] K_TRL  = 2'd2;
`endif
  localparam logic [15:0] LAST_CNT = 16'(PAYLOAD_WORDS);

  logic [1:0]    state, state_nxt;
  logic [15:0]   seq, pay_cnt;
  logic [2:0]    flags, flags_nxt;
  logic          closed;
  logic          s1_valid, s1_sop, s1_eop, s1_err;
  logic [1:0]    s1_kind, s1_addr;
  logic          start, hdr_take, pay_take, drop_rd, trunc, last_rd;
  logic          stage_valid, stage_eop, close_now, zero_word, eop_beat;
  logic [1:0]    stage_kind;
  logic [DW-1:0] hdr_word, out_word;
`ifdef TRAILER_CHECKSUM_EN
  logic          trl_take;
  logic [DW-1:0] chk;
`endif

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    hdr_take  = 1'b0;
    pay_take  = 1'b0;
    drop_rd   = 1'b0;
    trunc     = 1'b0;
`ifdef TRAILER_CHECKSUM_EN
    trl_take  = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (en && h_en && Header_Address == 2'd0) begin
          start     = 1'b1;
          hdr_take  = 1'b1;
          state_nxt = S_HDR;
        end
      end
      S_HDR: begin
        if (!en) begin
          trunc = 1'b1;
        end else if (h_en) begin
          hdr_take = 1'b1;
          drop_rd  = fifo_rd;
        end else begin
          pay_take  = fifo_rd;
          state_nxt = S_PAY;
        end
      end
      S_PAY: begin
        // closed: all payload accepted, absorb stray strobes until en drops
        if (closed) begin
          drop_rd = fifo_rd || h_en;
          if (!en) state_nxt = S_IDLE;
        end else if (!en) begin
          trunc = 1'b1;
        end else if (h_en) begin
          drop_rd = 1'b1;
        end else begin
          pay_take = fifo_rd;
        end
      end
`ifdef TRAILER_CHECKSUM_EN
      S_TAIL: begin
        trl_take = !closed;
        drop_rd  = fifo_rd || h_en;
        if (!en) state_nxt = S_IDLE;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase

    last_rd    = pay_take && (pay_cnt + 16'd1 == LAST_CNT);
    stage_kind = pay_take ? K_PAY : K_HDR;
`ifdef TRAILER_CHECKSUM_EN
    if (trunc || last_rd) state_nxt = S_TAIL;
    if (trl_take) stage_kind = K_TRL;
    stage_valid = hdr_take || pay_take || trl_take;
    zero_word   = 1'b0;
    stage_eop   = trl_take;
    close_now   = trl_take;
    eop_beat    = s1_valid && s1_eop;
`else
    if (trunc) state_nxt = S_IDLE;
    stage_valid = hdr_take || pay_take;
    // truncation with nothing in flight closes the frame with a marked empty word
    zero_word   = trunc && !s1_valid;
    stage_eop   = last_rd;
    close_now   = last_rd;
    eop_beat    = (s1_valid && (s1_eop || trunc)) || zero_word;
`endif
    flags_nxt = start ? 3'b000 : (flags | {trunc, drop_rd, pay_take && fifo_empty});

    case (s1_addr)
      2'd0:    hdr_word = DW'(SYNC_WORD);
      2'd1:    hdr_word = DW'(seq);
      2'd2:    hdr_word = DW'(PAYLOAD_WORDS);
      default: hdr_word = DW'(frame_status);
    endcase
    case (s1_kind)
      K_HDR:   out_word = hdr_word;
      K_PAY:   out_word = fifo_dout;
`ifdef TRAILER_CHECKSUM_EN
      K_TRL:   out_word = chk;
`endif
      default: out_word = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      seq          <= '0;
      pay_cnt      <= '0;
      flags        <= '0;
      closed       <= 1'b0;
      s1_valid     <= 1'b0;
      s1_kind      <= K_HDR;
      s1_addr      <= '0;
      s1_sop       <= 1'b0;
      s1_eop       <= 1'b0;
      s1_err       <= 1'b0;
      tx_data      <= '0;
      tx_valid     <= 1'b0;
      tx_sop       <= 1'b0;
      tx_eop       <= 1'b0;
      tx_err       <= 1'b0;
      frame_status <= '0;
      frames_sent  <= '0;
`ifdef TRAILER_CHECKSUM_EN
      chk          <= '0;
`endif
    end else begin
      state <= state_nxt;
      flags <= flags_nxt;
      if (start) pay_cnt <= '0;
      else if (pay_take) pay_cnt <= pay_cnt + 16'd1;
      if (start) closed <= 1'b0;
      else if (close_now) closed <= 1'b1;

      s1_valid <= stage_valid;
      s1_kind  <= stage_kind;
      s1_addr  <= Header_Address;
      s1_sop   <= hdr_take && Header_Address == 2'd0;
      s1_err   <= pay_take && fifo_empty;
      s1_eop   <= stage_eop;

      tx_valid <= s1_valid || zero_word;
      tx_sop   <= s1_valid && s1_sop;
      tx_eop   <= eop_beat;
      tx_err   <= (s1_valid && s1_err) || zero_word;
      tx_data  <= s1_valid ? out_word : '0;

      // flags_nxt so that strobes seen on the eop beat itself still count
      if (eop_beat) begin
        frame_status <= flags_nxt;
        seq          <= seq + 16'd1;
        frames_sent  <= frames_sent + 16'd1;
      end
`ifdef TRAILER_CHECKSUM_EN
      if (start) chk <= '0;
      else if (s1_valid && s1_kind == K_PAY) chk <= chk ^ fifo_dout;
`endif
    end
  end

endmodule

// File: doc/eth_frame_builder.md
Name: eth_frame_builder

Overview:
- Downstream of the frame-sequencing controller; consumes its `en`, `h_en`, `Header_Address` and `fifo_rd` strobes plus the data FIFO's read port.
- Produces one framed word stream (4 header words, then payload, optionally a trailer) with sop/eop/valid/err for the Ethernet transmit module.
- Generates header contents, counts payload, detects FIFO underflow, over-read and truncation, and keeps frame statistics.

Parameters:
- DW, 16, data word width; minimum 16.
- PAYLOAD_WORDS, 4096, payload words per frame; minimum 1.
- SYNC_WORD, 16'hA55A, constant for header word 0, zero-extended to DW.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  frame-active enable from the controller
- h_en  in  1  header phase strobe
- Header_Address  in  2  header word index, valid while h_en=1
- fifo_rd  in  1  FIFO read strobe (also drives the FIFO)
- fifo_empty  in  1  FIFO empty flag, sampled with fifo_rd
- fifo_dout  in  DW  FIFO read data, valid 1 cycle after fifo_rd
- tx_data  out  DW  output word
- tx_valid  out  1  tx_data valid
- tx_sop  out  1  first word of frame
- tx_eop  out  1  last word of frame
- tx_err  out  1  current word is corrupt (underflow read)
- frame_status  out  3  {truncated, overrun, underflow} of last completed frame
- frames_sent  out  16  completed frame count, wraps at 16'hFFFF->0

Behaviour:
- Reset: all outputs, seq counter, payload counter and checksum go to 0; state goes to IDLE. Reset mid-frame abandons the frame with no eop and no count increment.
- States: IDLE, HDR, PAY, TAIL (TAIL only when the feature is enabled).
- IDLE->HDR: h_en=1 && Header_Address==0. Per-frame error flags clear and the payload counter clears on this transition.
- Header words by address:
  - 0 = SYNC_WORD
  - 1 = seq (16-bit, zero-extended)
  - 2 = PAYLOAD_WORDS
  - 3 = {0, frame_status}
- Header path latency is 2 cycles: address sampled at t into a stage register, tx_data at t+2. The word for address 0 carries tx_sop=1.
- HDR->PAY: first cycle with h_en=0 && en=1.
- Payload path latency is 2 cycles: fifo_rd at t, fifo_dout captured at t+1, tx_data at t+2. Header and payload therefore stream back to back with no bubble.
- Each accepted read increments the payload counter (16-bit). The read that makes the counter reach PAYLOAD_WORDS is the last payload word.
- Over-read: fifo_rd=1 after PAYLOAD_WORDS words are accepted. The word is dropped (no tx_valid) and the overrun flag is set. Extra reads are absorbed until en=0.
- Underflow: fifo_rd=1 && fifo_empty=1. The word is still emitted, with tx_err=1, and the underflow flag is set.
- Truncation: en falls in HDR or PAY before PAYLOAD_WORDS are accepted. The last already-emitted pipeline word gets tx_eop=1; if none is in flight, a single DW'0 word is emitted with tx_eop=1 and tx_err=1. The truncated flag is set.
- Frame end (the eop beat):
  - frame_status <= per-frame flags
  - seq += 1
  - frames_sent += 1
  - state returns to IDLE once en=0.
- en=0 while in IDLE keeps the block idle. h_en while in PAY is ignored and sets the overrun flag.
- When h_en=1 and fifo_rd=1 in the same cycle, h_en has priority; the FIFO word is dropped and the overrun flag is set.
- tx_valid is never asserted outside a frame. tx_sop and tx_eop assert only together with tx_valid.

Optional Feature:
- Macro TRAILER_CHECKSUM_EN.
- Defined:
  - Running XOR of all emitted payload words (including tx_err words); starts at 0 each frame.
  - After the last payload word, PAY->TAIL and one trailer word = checksum is emitted 1 cycle after the last payload beat, with tx_eop=1. This holds for truncated frames too.
  - Frame length = 4 + PAYLOAD_WORDS + 1.
- Undefined: no TAIL state; tx_eop sits on the last payload word.

Test Plan:
- PAYLOAD_WORDS=8, FIFO preloaded 1..8, controller-style strobes -> tx words A55A,0,8,0,1..8 contiguous; sop on A55A, eop on 8; frames_sent=1. With the feature: trailer 0x0008 (XOR 1..8) carries eop.
- Two back-to-back frames -> second header word1=1, word3=0; frames_sent=2.
- 9 fifo_rd pulses with PAYLOAD_WORDS=8 -> 9th word dropped; frame_status=3'b010; next frame's header word3=0x0002.
- fifo_empty=1 on 3rd read -> payload word 3 has tx_err=1; frame_status=3'b001.
- en falls after 5 payload reads -> eop on word 5; frame_status=3'b100; seq increments.
- rst asserted mid-payload -> all outputs 0 immediately; next frame seq=0 with sop on A55A.
